// File: rtl/hdr_tonemap.sv
// Log-radiance to RGB565 tone mapper: per-channel offset/shift taken from the previous
// frame's min/max, two-stage pipeline, and a 4-entry first-word-fall-through output FIFO.
module hdr_tonemap #(
    parameter int N             = 16,
    parameter int FP            = 8,
    parameter int PIX_PER_FRAME = 76800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] lE_red,
    input  logic signed [N-1:0] lE_green,
    input  logic signed [N-1:0] lE_blue,
    input  logic                le_valid,
    output logic                le_ready,
    output logic [15:0]         pix_out,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                frame_done
);
    localparam int SH_W  = $clog2(N + 2);
    localparam int CNT_W = $clog2(PIX_PER_FRAME);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(PIX_PER_FRAME - 1);
    localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

    function automatic logic [SH_W-1:0] bit_len(input logic [N-1:0] span);
        logic [SH_W-1:0] l;
        l = '0;
        for (int i = 0; i < N; i++)
            if (span[i]) l = SH_W'(i + 1);
        return l;
    endfunction

    function automatic logic [SH_W-1:0] frame_shift(input logic [SH_W-1:0] l,
                                                    input logic [SH_W-1:0] bits);
        return (l > bits) ? l - bits : '0;
    endfunction

    // Negative offsets floor to zero, large values saturate at the channel limit.
    function automatic logic [5:0] map_chan(input logic signed [N:0]   d,
                                            input logic [SH_W-1:0]     sh,
                                            input logic [5:0]          lim);
        logic signed [N:0] v;
        v = d >>> sh;
        if (d < 0)
            return 6'd0;
        else if (v > $signed({{(N-5){1'b0}}, lim}))
            return lim;
        else
            return v[5:0];
    endfunction

    logic signed [N-1:0] le [3];
    logic signed [N-1:0] lo_q [3], lo_d [3], min_q [3], min_d [3], max_q [3], max_d [3];
    logic signed [N-1:0] mn [3], mx [3];
    logic [N-1:0]        span [3];
    logic [SH_W-1:0]     len [3], sh_q [3], sh_d [3], sh_p1_q [3];
    logic signed [N:0]   d_p1_q [3], d_p1_d [3];
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [4:0]          r5, b5;
    logic [5:0]          g6;
    logic [15:0]         pix_p2_q, pix_p2_d;
    logic [15:0]         mem_q [4];
    logic [1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                frame_done_q, frame_done_d;
    logic                accept, last_in, push, pop;

    assign le[0] = lE_red;
    assign le[1] = lE_green;
    assign le[2] = lE_blue;

    assign le_ready   = (4'(cnt_q) + 4'(vld_p1_q) + 4'(vld_p2_q)) < 4'd4;
    assign pix_valid  = (cnt_q != 3'd0);
    assign pix_out    = mem_q[rd_ptr_q];
    assign frame_done = frame_done_q;

    // Accept / statistics: the last pixel's value is folded in before the frame closes.
    always_comb begin
        accept   = le_valid && le_ready;
        last_in  = (in_cnt_q == LAST);
        in_cnt_d = in_cnt_q;
        vld_p1_d = accept;
        if (accept) in_cnt_d = last_in ? '0 : in_cnt_q + 1'b1;
        for (int c = 0; c < 3; c++) begin
            mn[c]     = (le[c] < min_q[c]) ? le[c] : min_q[c];
            mx[c]     = (le[c] > max_q[c]) ? le[c] : max_q[c];
            span[c]   = mx[c] - mn[c];
            len[c]    = bit_len(span[c]);
            d_p1_d[c] = {le[c][N-1], le[c]} - {lo_q[c][N-1], lo_q[c]};
            lo_d[c]   = lo_q[c];
            sh_d[c]   = sh_q[c];
            min_d[c]  = min_q[c];
            max_d[c]  = max_q[c];
            if (accept) begin
                min_d[c] = mn[c];
                max_d[c] = mx[c];
                if (last_in) begin
                    lo_d[c]  = mn[c];
                    sh_d[c]  = frame_shift(len[c], (c == 1) ? SH_W'(6) : SH_W'(5));
                    min_d[c] = S_MAX;
                    max_d[c] = S_MIN;
                end
            end
        end
    end

    // S2: shift, clamp and pack
    always_comb begin
        vld_p2_d = vld_p1_q;
        r5       = 5'(map_chan(d_p1_q[0], sh_p1_q[0], 6'd31));
        g6       = map_chan(d_p1_q[1], sh_p1_q[1], 6'd63);
        b5       = 5'(map_chan(d_p1_q[2], sh_p1_q[2], 6'd31));
        pix_p2_d = {r5, g6, b5};
    end

    // Output FIFO and pop-side frame counter
    always_comb begin
        push         = vld_p2_q;
        pop          = pix_valid && pix_ready;
        wr_ptr_d     = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        cnt_d        = cnt_q + {2'b00, push} - {2'b00, pop};
        out_cnt_d    = out_cnt_q;
        frame_done_d = 1'b0;
        if (pop) begin
            out_cnt_d    = (out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1;
            frame_done_d = (out_cnt_q == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                lo_q[c]  <= '0;
                sh_q[c]  <= (c == 1) ? SH_W'(FP - 3) : SH_W'(FP - 2);
                min_q[c] <= S_MAX;
                max_q[c] <= S_MIN;
            end
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            frame_done_q <= frame_done_d;
            for (int c = 0; c < 3; c++) begin
                lo_q[c]  <= lo_d[c];
                sh_q[c]  <= sh_d[c];
                min_q[c] <= min_d[c];
                max_q[c] <= max_d[c];
            end
        end
    end

    // Datapath registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            d_p1_q[c]  <= d_p1_d[c];
            sh_p1_q[c] <= sh_q[c];
        end
        pix_p2_q <= pix_p2_d;
        if (push) mem_q[wr_ptr_q] <= pix_p2_q;
    end
endmodule

// File: tb/tb_hdr_tonemap.sv
// Scoreboard bench for hdr_tonemap with a 4-pixel frame.
module tb_hdr_tonemap;
    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] lE_red, lE_green, lE_blue;
    logic               le_valid, le_ready;
    logic [15:0]        pix_out;
    logic               pix_valid, pix_ready, frame_done;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pops[$];
    int mlo[3], msh[3], mmin[3], mmax[3];
    int min_cnt, mout_cnt, n_acc, n_fd;
    logic fd_exp;

    hdr_tonemap #(.N(16), .FP(8), .PIX_PER_FRAME(4)) dut (
        .clk(clk), .rst(rst), .lE_red(lE_red), .lE_green(lE_green), .lE_blue(lE_blue),
        .le_valid(le_valid), .le_ready(le_ready), .pix_out(pix_out), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mlo[c]  = 0;
            mmin[c] = 32767;
            mmax[c] = -32768;
        end
        msh[0] = 6; msh[1] = 5; msh[2] = 6;
        min_cnt = 0; mout_cnt = 0; fd_exp = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic signed [15:0] r, input logic signed [15:0] g,
                                input logic signed [15:0] b);
        int le[3];
        int v[3];
        int span, len, w, lim;
        le[0] = r; le[1] = g; le[2] = b;
        for (int c = 0; c < 3; c++) begin
            v[c] = le[c] - mlo[c];
            lim  = (c == 1) ? 63 : 31;
            if (v[c] < 0) v[c] = 0;
            else v[c] = v[c] >> msh[c];
            if (v[c] > lim) v[c] = lim;
        end
        exp_q.push_back(16'((v[0] << 11) | (v[1] << 5) | v[2]));
        for (int c = 0; c < 3; c++) begin
            if (le[c] < mmin[c]) mmin[c] = le[c];
            if (le[c] > mmax[c]) mmax[c] = le[c];
        end
        if (min_cnt == 3) begin
            for (int c = 0; c < 3; c++) begin
                mlo[c] = mmin[c];
                span   = mmax[c] - mmin[c];
                len    = 0;
                while (len < 32 && (span >> len) != 0) len++;
                w      = (c == 1) ? 6 : 5;
                msh[c] = (len > w) ? len - w : 0;
                mmin[c] = 32767;
                mmax[c] = -32768;
            end
            min_cnt = 0;
        end else begin
            min_cnt++;
        end
        n_acc++;
    endtask

    // One clock: sample handshakes before the edge, update model/scoreboard #1 after it.
    task automatic cycle();
        logic acc, pp;
        logic [15:0] po;
        logic signed [15:0] r, g, b;
        acc = le_valid && le_ready;
        pp  = pix_valid && pix_ready;
        po  = pix_out;
        r = lE_red; g = lE_green; b = lE_blue;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (acc) model_accept(r, g, b);
            fd_exp = 1'b0;
            if (pp) begin
                pops.push_back(po);
                if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                else check("pix_out", po, exp_q.pop_front());
                fd_exp = (mout_cnt == 3);
                mout_cnt = (mout_cnt + 1) % 4;
            end
            check("frame_done", frame_done, fd_exp);
            if (frame_done) n_fd++;
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] r, input logic [15:0] g,
                         input logic [15:0] b);
        le_valid = v;
        lE_red = r; lE_green = g; lE_blue = b;
    endtask

    initial begin
        logic [15:0] reds[6];
        int base, fd0, acc0, guard;
        reds = '{16'h0200, 16'h0300, 16'h0400, 16'h0600, 16'h0600, 16'h0100};
        n_acc = 0; n_fd = 0;
        rst = 1'b1; pix_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        model_reset();
        cycle(); cycle();
        rst = 1'b0;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_le_ready", le_ready, 1);

        // single pixel latency and mapping
        pix_ready = 1'b1;
        drive(1'b1, 16'h0100, 16'h0100, 16'h0000);
        cycle();
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        cycle(); check("t1_valid_k1", pix_valid, 0);
        cycle(); check("t1_valid_k2", pix_valid, 1); check("t1_pix", pix_out, 16'h2100);
        cycle(); check("t1_single", pix_valid, 0);

        // negative floor and clamps
        drive(1'b1, 16'hFF00, 16'h7FFF, 16'h07C0);
        cycle();
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        repeat (3) cycle();
        check("t2_npops", pops.size(), 2);
        check("t2_pix", pops[pops.size()-1], 16'h07FF);

        // frame statistics update
        rst = 1'b1; cycle(); rst = 1'b0;
        pops.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, reds[i], 16'h0, 16'h0);
            cycle();
        end
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        repeat (4) cycle();
        check("t3_npops", pops.size(), 6);
        check("t3_last_of_f1", pops[3], 16'hC000);
        check("t3_f2_p0", pops[4], 16'h8000);
        check("t3_f2_p1", pops[5], 16'h0000);

        // backpressure: 4 credits then stall
        pix_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
            cycle();
        end
        check("t4_accepts", n_acc - acc0, 4);
        check("t4_le_ready", le_ready, 0);
        check("t4_pix_valid", pix_valid, 1);
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        pix_ready = 1'b1;
        repeat (8) cycle();
        check("t4_drained", exp_q.size(), 0);
        check("t4_le_ready_back", le_ready, 1);

        // reset with data in flight
        pix_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
            cycle();
        end
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        repeat (2) cycle();
        check("t5_pre_valid", pix_valid, 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        check("t5_pix_valid", pix_valid, 0);
        check("t5_frame_done", frame_done, 0);
        check("t5_le_ready", le_ready, 1);
        pix_ready = 1'b1;
        base = pops.size();
        fd0 = n_fd;
        drive(1'b1, 16'h0100, 16'h0100, 16'h0080);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
            cycle();
        end
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        repeat (4) cycle();
        check("t5_first_pix", pops[base], 16'h2102);
        check("t5_frames", n_fd - fd0, 1);

        // three back-to-back frames under random backpressure
        fd0 = n_fd;
        acc0 = n_acc;
        guard = 0;
        while (n_acc < acc0 + 12 && guard < 500) begin
            drive(n_acc < acc0 + 12, 16'($urandom), 16'($urandom), 16'($urandom));
            pix_ready = ($urandom_range(0, 3) == 0);
            cycle();
            guard++;
        end
        check("t6_no_timeout", 32'(guard < 500), 1);
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        pix_ready = 1'b1;
        repeat (8) cycle();
        check("t6_frames", n_fd - fd0, 3);
        check("t6_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
